brq_hpm_counter_bank: RTL
=========================

BRQ_HPM_COUNTER_BANK -- requirements
Module: brq_hpm_counter_bank

Interface
REQ-001 SHALL have parameter MHPMCounterNum, default 8, number of programmable counters (0..29).
REQ-002 SHALL have parameter MHPMCounterWidth, default 40, width of each programmable counter (1..64).
REQ-003 SHALL have parameter NumEvents, default 16, width of the event bus (1..32).
REQ-004 SHALL have port clk_i, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i, input, 1, reset; synchronous and active-high.
REQ-006 SHALL have port csr_access_i, input, 1, CSR access request this cycle.
REQ-007 SHALL have port csr_we_i, input, 1, write qualifier for csr_access_i.
REQ-008 SHALL have port csr_addr_i, input, 12, CSR number (csr_num_e).
REQ-009 SHALL have port csr_wdata_i, input, 32, write data.
REQ-010 SHALL have port csr_rvalid_o, output, 1, response pulse one cycle after every access.
REQ-011 SHALL have port csr_rdata_o, output, 32, read data, valid with csr_rvalid_o.
REQ-012 SHALL have port csr_illegal_o, output, 1, unsupported address, valid with csr_rvalid_o.
REQ-013 SHALL have port instr_ret_i, input, 1, one instruction retired this cycle.
REQ-014 SHALL have port event_i, input, NumEvents, per-cycle event strobes.
REQ-015 SHALL have port ovf_irq_o, output, 1, overflow interrupt request (macro-dependent).

Function
REQ-016 SHALL implement mcycle (B00/B80) and minstret (B02/B82) at 64 bits, plus mhpmcounter3..(3+MHPMCounterNum-1) at MHPMCounterWidth, low/high words at B03+/B83+.
REQ-017 SHALL implement mcountinhibit (320) with bit0=mcycle, bit2=minstret, bit(3+k)=counter k; bit1 and unimplemented bits read 0, ignore writes.
REQ-018 SHALL implement mhpmeventN (323+k) as a NumEvents-bit mask; upper bits read 0.
REQ-019 SHALL increment mcycle by 1 every non-inhibited cycle, minstret on instr_ret_i, counter k when |(event_i & mhpmevent[k]); increment never exceeds 1 per cycle.
REQ-020 SHALL latch the read mux at access time; response exactly 1 cycle later; read of an address written in the same access returns the pre-write value.
REQ-021 SHALL give a CSR write priority over a same-cycle increment of the same counter; a write to a low/high word leaves the other word unchanged.
REQ-022 SHALL read bits at or above MHPMCounterWidth as 0; for width 32 or less, high words read 0 and writes to them are ignored but legal.
REQ-023 SHALL wrap an all-ones counter to 0 on increment.
REQ-024 SHALL flag any address outside REQ-016..018, and any hpm index at or above MHPMCounterNum, as illegal: rdata 0, no state change.
REQ-025 SHALL accept back-to-back accesses every cycle with no stall.

Reset
REQ-026 SHALL clear all counters, mhpmevent masks, overflow state, csr_rvalid_o, csr_rdata_o, csr_illegal_o and ovf_irq_o on rst_i; mcountinhibit resets to 0.
REQ-027 SHALL make rst_i override a same-cycle access or increment, and SHALL NOT issue a response for an access accepted in the cycle before reset.

Configuration
REQ-028 SHALL use macro BRQ_HPM_OVERFLOW_IRQ_EN.
REQ-029 With the macro: each counter wrap per REQ-023 sets sticky ovf[i], indexed as mcountinhibit, and a counter write in the same cycle suppresses it.
REQ-030 With the macro: CSR_MHPMOVF (7C2) reads ovf with write-1-to-clear; CSR_MHPMOVFEN (7C3) is read/write; ovf_irq_o = |(ovf & ovfen), registered.
REQ-031 Without the macro: no overflow state exists, 7C2/7C3 are illegal, and ovf_irq_o is tied 0.

Structure
REQ-032 SHALL add CSR_MHPMOVF and CSR_MHPMOVFEN to csr_num_e in brq_pkg, and SHALL use existing brq_pkg CSR numbers.
REQ-033 SHALL use one sub-module, brq_hpm_counter (parametrised width, increment, word-write, wrap flag), instantiated per counter.

Verification
REQ-034 Reset, then 10 idle cycles, then read B00 -> rdata 10 (+/-1 per documented pipeline alignment), rvalid one cycle later.
REQ-035 Write mhpmevent3=0x0005, pulse event_i[0] and event_i[2] together 4 cycles -> B03 reads 4.
REQ-036 MHPMCounterWidth=40: write B83=0xFFFF_FFFF, B03=0xFFFF_FFFF -> B83 reads 0x0000_00FF; next increment -> both read 0, ovf[3]=1 (macro on).
REQ-037 Write mcountinhibit=0x1 for 5 cycles -> mcycle unchanged; clear it -> counting resumes.
REQ-038 Read B0B with MHPMCounterNum=8 -> csr_illegal_o=1, rdata 0.
REQ-039 Macro on, ovfen bit3 set, counter 3 wraps -> ovf_irq_o=1 next cycle; write 7C2=0x8 -> ovf_irq_o=0.

Source files
------------

// File: rtl/brq_pkg.sv
// Shared CSR numbering and helpers for the hardware performance monitor.
// Slot indices follow mcountinhibit: 0=mcycle, 2=minstret, 3+k=mhpmcounter(3+k).
// No timing or backpressure: package only.
package brq_pkg;

  typedef enum logic [11:0] {
    CSR_MCOUNTINHIBIT  = 12'h320,
    CSR_MHPMEVENT3     = 12'h323,
    CSR_MHPMEVENT31    = 12'h33F,
    CSR_MHPMOVF        = 12'h7C2,
    CSR_MHPMOVFEN      = 12'h7C3,
    CSR_MCYCLE         = 12'hB00,
    CSR_MINSTRET       = 12'hB02,
    CSR_MHPMCOUNTER3   = 12'hB03,
    CSR_MHPMCOUNTER31  = 12'hB1F,
    CSR_MCYCLEH        = 12'hB80,
    CSR_MINSTRETH      = 12'hB82,
    CSR_MHPMCOUNTER3H  = 12'hB83,
    CSR_MHPMCOUNTER31H = 12'hB9F
  } csr_num_e;

  localparam int unsigned NumSlots    = 32;
  localparam int unsigned HpmFirstIdx = 3;
  localparam logic [11:0] CsrGroupMsk = 12'hFE0;

  // Bit set for every slot that physically exists (mcycle, minstret, hpm 3..3+num-1).
  function automatic logic [31:0] hpm_impl_mask(input int unsigned num);
    logic [31:0] m;
    m = 32'h0000_0005;
    for (int unsigned k = 0; k < 29; k++) begin
      if (k < num) m[HpmFirstIdx + k] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/brq_hpm_counter.sv
// Single performance counter of parametrised width with 32-bit word writes.
// Latency: write/increment visible the cycle after; no backpressure (always accepts).
module brq_hpm_counter #(
  parameter int unsigned Width = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inc_i,
  input  logic        we_lo_i,
  input  logic        we_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] value_o,
  output logic        wrap_o
);

  logic [Width-1:0] cnt_q;
  logic [63:0]      cur;
  logic [63:0]      wr_val;
  logic             unused_wr;

  // Bits above Width are dropped, so writes to an absent high word are harmless.
  always_comb begin
    cur              = '0;
    cur[Width-1:0]   = cnt_q;
    wr_val           = cur;
    if (we_lo_i) wr_val[31:0]  = wdata_i;
    if (we_hi_i) wr_val[63:32] = wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (we_lo_i || we_hi_i) begin
      cnt_q <= wr_val[Width-1:0];
    end else if (inc_i) begin
      cnt_q <= cnt_q + Width'(1);
    end
  end

  assign value_o   = cur;
  assign wrap_o    = inc_i & (&cnt_q) & ~(we_lo_i | we_hi_i);
  assign unused_wr = ^wr_val;

endmodule

// File: rtl/brq_hpm_counter_bank.sv
// mcycle/minstret/mhpmcounter bank with CSR access; overflow IRQ under BRQ_HPM_OVERFLOW_IRQ_EN.
// Latency: CSR response exactly 1 cycle after access; counters update every cycle.
// Backpressure: none, back-to-back accesses accepted every cycle.
module brq_hpm_counter_bank
  import brq_pkg::*;
#(
  parameter int unsigned MHPMCounterNum   = 8,
  parameter int unsigned MHPMCounterWidth = 40,
  parameter int unsigned NumEvents        = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 csr_access_i,
  input  logic                 csr_we_i,
  input  logic [11:0]          csr_addr_i,
  input  logic [31:0]          csr_wdata_i,
  output logic                 csr_rvalid_o,
  output logic [31:0]          csr_rdata_o,
  output logic                 csr_illegal_o,
  input  logic                 instr_ret_i,
  input  logic [NumEvents-1:0] event_i,
  output logic                 ovf_irq_o
);

  localparam logic [31:0] ImplMask = hpm_impl_mask(MHPMCounterNum);

  logic [4:0]           idx;
  logic                 sel_inh, sel_evt, sel_lo, sel_hi, sel_ovf, sel_ovfen, legal;
  logic                 wr_en;
  logic [31:0]          rd_val;
  logic [31:0]          inhibit_q;
  logic [31:0]          ovf_rd, ovfen_rd;
  logic [31:0]          wrap;
  logic [63:0]          cnt_val  [NumSlots];
  logic [NumEvents-1:0] evt_mask [NumSlots];
  logic                 rvalid_q, illegal_q;
  logic [31:0]          rdata_q;

  assign idx = csr_addr_i[4:0];

  always_comb begin
    sel_inh   = (csr_addr_i == CSR_MCOUNTINHIBIT);
    sel_evt   = ((csr_addr_i & CsrGroupMsk) == CSR_MCOUNTINHIBIT) &&
                (idx >= 5'(HpmFirstIdx)) && ImplMask[idx];
    sel_lo    = ((csr_addr_i & CsrGroupMsk) == CSR_MCYCLE)  && ImplMask[idx];
    sel_hi    = ((csr_addr_i & CsrGroupMsk) == CSR_MCYCLEH) && ImplMask[idx];
`ifdef BRQ_HPM_OVERFLOW_IRQ_EN
    sel_ovf   = (csr_addr_i == CSR_MHPMOVF);
    sel_ovfen = (csr_addr_i == CSR_MHPMOVFEN);
`else
    sel_ovf   = 1'b0;
    sel_ovfen = 1'b0;
`endif
    legal     = sel_inh | sel_evt | sel_lo | sel_hi | sel_ovf | sel_ovfen;
  end

  assign wr_en = csr_access_i & csr_we_i;

  // Read mux works on current state, so a same-access write returns the old value.
  always_comb begin
    rd_val = '0;
    if (sel_inh)   rd_val = inhibit_q;
    if (sel_evt)   rd_val[NumEvents-1:0] = evt_mask[idx];
    if (sel_lo)    rd_val = cnt_val[idx][31:0];
    if (sel_hi)    rd_val = cnt_val[idx][63:32];
    if (sel_ovf)   rd_val = ovf_rd;
    if (sel_ovfen) rd_val = ovfen_rd;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inhibit_q <= '0;
    end else if (wr_en && sel_inh) begin
      inhibit_q <= csr_wdata_i & ImplMask;
    end
  end

  for (genvar i = 0; i < NumSlots; i++) begin : g_slot
    if (i == 0 || i == 2) begin : g_fixed
      logic inc;
      assign inc = ~inhibit_q[i] & ((i == 0) ? 1'b1 : instr_ret_i);
      brq_hpm_counter #(.Width(64)) u_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (inc),
        .we_lo_i (wr_en && sel_lo && idx == 5'(i)),
        .we_hi_i (wr_en && sel_hi && idx == 5'(i)),
        .wdata_i (csr_wdata_i),
        .value_o (cnt_val[i]),
        .wrap_o  (wrap[i])
      );
      assign evt_mask[i] = '0;
    end else if (ImplMask[i]) begin : g_hpm
      logic                 inc;
      logic [NumEvents-1:0] mask_q;
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          mask_q <= '0;
        end else if (wr_en && sel_evt && idx == 5'(i)) begin
          mask_q <= csr_wdata_i[NumEvents-1:0];
        end
      end
      assign inc = ~inhibit_q[i] & (|(event_i & mask_q));
      brq_hpm_counter #(.Width(MHPMCounterWidth)) u_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (inc),
        .we_lo_i (wr_en && sel_lo && idx == 5'(i)),
        .we_hi_i (wr_en && sel_hi && idx == 5'(i)),
        .wdata_i (csr_wdata_i),
        .value_o (cnt_val[i]),
        .wrap_o  (wrap[i])
      );
      assign evt_mask[i] = mask_q;
    end else begin : g_absent
      assign cnt_val[i]  = '0;
      assign evt_mask[i] = '0;
      assign wrap[i]     = 1'b0;
    end
  end

`ifdef BRQ_HPM_OVERFLOW_IRQ_EN
  logic [31:0] ovf_q, ovfen_q, ovf_n, ovfen_n;
  logic        irq_q;

  // A wrap in the same cycle as a write-1-to-clear keeps the flag set.
  always_comb begin
    ovf_n   = ovf_q;
    ovfen_n = ovfen_q;
    if (wr_en && sel_ovf)   ovf_n   = ovf_q & ~csr_wdata_i;
    if (wr_en && sel_ovfen) ovfen_n = csr_wdata_i & ImplMask;
    ovf_n = (ovf_n | wrap) & ImplMask;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovf_q   <= '0;
      ovfen_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      ovf_q   <= ovf_n;
      ovfen_q <= ovfen_n;
      irq_q   <= |(ovf_n & ovfen_n);
    end
  end

  assign ovf_rd    = ovf_q;
  assign ovfen_rd  = ovfen_q;
  assign ovf_irq_o = irq_q;
`else
  logic unused_wrap;
  assign unused_wrap = ^wrap;
  assign ovf_rd      = '0;
  assign ovfen_rd    = '0;
  assign ovf_irq_o   = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      rvalid_q <= csr_access_i;
      if (csr_access_i) begin
        rdata_q   <= rd_val;
        illegal_q <= ~legal;
      end
    end
  end

  // Reset in the response cycle squashes the pending response.
  assign csr_rvalid_o  = rvalid_q & ~rst_i;
  assign csr_rdata_o   = rdata_q;
  assign csr_illegal_o = illegal_q;

endmodule
